// File: rtl/wb_tick_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_tick_timer_if
// Description : Wishbone B3 signal bundle for the tick timer slave. Signal
//               names keep the slave-side _i/_o suffixes used throughout
//               the system interconnect, so the slave modport reads
//               naturally.
//               Signals:
//                 wb_adr_i [31:0]  byte address (only [7:2] decoded)
//                 wb_dat_i [31:0]  write data
//                 wb_sel_i [3:0]   byte lane enables
//                 wb_we_i          write enable
//                 wb_cyc_i         cycle valid
//                 wb_stb_i         strobe
//                 wb_cti_i [2:0]   cycle type identifier
//                 wb_bte_i [1:0]   burst type extension
//                 wb_dat_o [31:0]  read data
//                 wb_ack_o         transfer acknowledge
//                 wb_err_o         error acknowledge
//                 wb_rty_o         retry (never used by the timer)
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_tick_timer_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport slave (
        input  wb_adr_i,
        input  wb_dat_i,
        input  wb_sel_i,
        input  wb_we_i,
        input  wb_cyc_i,
        input  wb_stb_i,
        input  wb_cti_i,
        input  wb_bte_i,
        output wb_dat_o,
        output wb_ack_o,
        output wb_err_o,
        output wb_rty_o
    );

    modport master (
        output wb_adr_i,
        output wb_dat_i,
        output wb_sel_i,
        output wb_we_i,
        output wb_cyc_i,
        output wb_stb_i,
        output wb_cti_i,
        output wb_bte_i,
        input  wb_dat_o,
        input  wb_ack_o,
        input  wb_err_o,
        input  wb_rty_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : wb_tick_timer
// Description : Wishbone B3 slave periodic timer. A programmable 8-bit
//               prescaler generates ticks; each tick advances COUNT, and a
//               COUNT==COMPARE match on a tick sets the sticky PEND flag,
//               which (masked by IE) drives the level interrupt int_o.
//
//               Register map (byte offset, adr[1:0] ignored):
//                 0x00 CTRL    [0] EN, [1] IE, [2] AUTO, [15:8] PRESCALE
//                 0x04 COUNT   read/write
//                 0x08 COMPARE read/write
//                 0x0C STATUS  [0] PEND, write 1 to clear
//               Offsets 0x10-0xFF answer with wb_err_o.
//
// Ports       : wb_clk_i  - system clock, rising edge
//               wb_rst_i  - synchronous active-high reset
//               bus       - Wishbone slave modport (wb_tick_timer_if)
//               int_o     - level interrupt request (PEND & IE)
// Parameters  : CNT_W        - counter/compare width (1..32)
//               RST_PRESCALE - reset value of CTRL.PRESCALE
// Revision    : 1.0 - initial release
// ============================================================================
module wb_tick_timer #(
    parameter int         CNT_W        = 32,
    parameter logic [7:0] RST_PRESCALE = 8'd0
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_tick_timer_if.slave bus,
    output logic           int_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]       c_reg_ctrl    = 2'd0;
    localparam logic [1:0]       c_reg_count   = 2'd1;
    localparam logic [1:0]       c_reg_compare = 2'd2;
    localparam logic [1:0]       c_reg_status  = 2'd3;
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_ones    = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic             r_ack;
    logic             r_err;
    logic [31:0]      r_dat;
    logic             r_en;
    logic             r_ie;
    logic             r_auto;
    logic [7:0]       r_prescale;
    logic [7:0]       r_pre_cnt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_compare;
    logic             r_pend;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic             w_req;
    logic             w_hit;
    logic             w_wr;
    logic [1:0]       w_reg;
    logic             w_wr_ctrl;
    logic             w_wr_count;
    logic             w_wr_compare;
    logic             w_clr_pend;
    logic             w_tick;
    logic             w_match;
    logic [31:0]      w_ctrl_rd;
    logic [31:0]      w_count_rd;
    logic [31:0]      w_compare_rd;
    logic [31:0]      w_rd_data;
    logic [31:0]      w_ctrl_new;
    logic [31:0]      w_count_new;
    logic [31:0]      w_compare_new;
    logic             w_unused;

    // Byte-lane merge: lanes with sel=1 take the bus data, others keep the
    // current register contents.
    function automatic logic [31:0] f_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    // The ack/err terms stop a held strobe from being taken twice: each beat
    // of a burst costs a request cycle plus an acknowledge cycle.
    assign w_req        = bus.wb_cyc_i & bus.wb_stb_i & ~r_ack & ~r_err;
    assign w_hit        = (bus.wb_adr_i[7:4] == 4'h0);
    assign w_reg        = bus.wb_adr_i[3:2];
    assign w_wr         = w_req & w_hit & bus.wb_we_i;
    assign w_wr_ctrl    = w_wr & (w_reg == c_reg_ctrl);
    assign w_wr_count   = w_wr & (w_reg == c_reg_count);
    assign w_wr_compare = w_wr & (w_reg == c_reg_compare);
    assign w_clr_pend   = w_wr & (w_reg == c_reg_status) &
                          bus.wb_sel_i[0] & bus.wb_dat_i[0];

    // Zero-extended views of the registers for reads and lane merging.
    always_comb begin
        w_ctrl_rd              = 32'h0;
        w_ctrl_rd[0]           = r_en;
        w_ctrl_rd[1]           = r_ie;
        w_ctrl_rd[2]           = r_auto;
        w_ctrl_rd[15:8]        = r_prescale;
        w_count_rd             = 32'h0;
        w_count_rd[CNT_W-1:0]  = r_count;
        w_compare_rd           = 32'h0;
        w_compare_rd[CNT_W-1:0] = r_compare;
    end

    always_comb begin
        w_rd_data = 32'h0;
        case (w_reg)
            c_reg_ctrl:    w_rd_data = w_ctrl_rd;
            c_reg_count:   w_rd_data = w_count_rd;
            c_reg_compare: w_rd_data = w_compare_rd;
            c_reg_status:  w_rd_data = {31'h0, r_pend};
            default:       w_rd_data = 32'h0;
        endcase
    end

    assign w_ctrl_new    = f_merge(w_ctrl_rd,    bus.wb_dat_i, bus.wb_sel_i);
    assign w_count_new   = f_merge(w_count_rd,   bus.wb_dat_i, bus.wb_sel_i);
    assign w_compare_new = f_merge(w_compare_rd, bus.wb_dat_i, bus.wb_sel_i);

    // ------------------------------------------------------------------------
    // Tick and match
    // ------------------------------------------------------------------------
    assign w_tick  = r_en & (r_pre_cnt == r_prescale);
    // A COUNT write on a tick cycle suppresses the compare entirely.
    assign w_match = w_tick & ~w_wr_count & (r_count == r_compare);

    // ------------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat      <= 32'h0;
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_auto     <= 1'b0;
            r_prescale <= RST_PRESCALE;
            r_pre_cnt  <= 8'd0;
            r_count    <= '0;
            r_compare  <= c_cnt_ones;
            r_pend     <= 1'b0;
        end else begin
            // Bus response: one-cycle ack or err; data only during ack.
            r_ack <= w_req & w_hit;
            r_err <= w_req & ~w_hit;
            r_dat <= (w_req & w_hit) ? w_rd_data : 32'h0;

            if (w_wr_ctrl) begin
                r_en       <= w_ctrl_new[0];
                r_ie       <= w_ctrl_new[1];
                r_auto     <= w_ctrl_new[2];
                r_prescale <= w_ctrl_new[15:8];
            end

            if (w_wr_compare) begin
                r_compare <= w_compare_new[CNT_W-1:0];
            end

            // Holding pre_cnt at 0 while disabled makes an EN 0->1 write
            // start a fresh prescale period.
            if (!r_en) begin
                r_pre_cnt <= 8'd0;
            end else if (w_tick) begin
                r_pre_cnt <= 8'd0;
            end else begin
                r_pre_cnt <= r_pre_cnt + 8'd1;
            end

            if (w_wr_count) begin
                r_count <= w_count_new[CNT_W-1:0];
            end else if (w_match) begin
                r_count <= r_auto ? '0 : r_count + c_cnt_one;
            end else if (w_tick) begin
                r_count <= r_count + c_cnt_one;
            end

            // Set beats clear when both land on the same edge.
            if (w_match) begin
                r_pend <= 1'b1;
            end else if (w_clr_pend) begin
                r_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.wb_ack_o = r_ack;
    assign bus.wb_err_o = r_err;
    assign bus.wb_dat_o = r_dat;
    assign bus.wb_rty_o = 1'b0;

    // Both operands are flops, so the AND cannot glitch.
    assign int_o = r_pend & r_ie;

    // Inputs and merge bits that carry no function in this block.
    assign w_unused = &{1'b0, bus.wb_cti_i, bus.wb_bte_i,
                        bus.wb_adr_i[31:8], bus.wb_adr_i[1:0],
                        w_ctrl_new[31:16], w_ctrl_new[7:3],
                        w_count_new, w_compare_new};

endmodule
`default_nettype wire

// File: tb/tb_wb_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_tick_timer
// Description : Self-checking bench for wb_tick_timer. Directed steps walk
//               the register map, handshake, interrupt timing and corner
//               cases; a randomized section compares COUNT/PEND/int_o with
//               a tick-level reference model computed from elapsed cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_tick_timer;

    localparam logic [31:0] c_a_ctrl    = 32'h00;
    localparam logic [31:0] c_a_count   = 32'h04;
    localparam logic [31:0] c_a_compare = 32'h08;
    localparam logic [31:0] c_a_status  = 32'h0C;

    logic clk = 1'b0;
    logic rst;
    logic int_o;
    int   n_total = 0;
    int   n_pass  = 0;

    wb_tick_timer_if bus ();

    wb_tick_timer #(
        .CNT_W        (32),
        .RST_PRESCALE (8'd0)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus),
        .int_o    (int_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single transfer: request edge, then one idle edge for ack to drop.
    task automatic xfer(input logic [31:0] a, input logic we, input logic [31:0] d,
                        input logic [3:0] sel, output logic [31:0] rdat,
                        output logic ack1, output logic err1,
                        output logic ack2, output logic err2);
        bus.wb_adr_i = a;
        bus.wb_we_i  = we;
        bus.wb_dat_i = d;
        bus.wb_sel_i = sel;
        bus.wb_cti_i = 3'b000;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        @(posedge clk);
        #1;
        rdat = bus.wb_dat_o;
        ack1 = bus.wb_ack_o;
        err1 = bus.wb_err_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        @(posedge clk);
        #1;
        ack2 = bus.wb_ack_o;
        err2 = bus.wb_err_o;
    endtask

    task automatic wr_sel(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        logic k1, k2, k3, k4;
        xfer(a, 1'b1, d, sel, r, k1, k2, k3, k4);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_sel(a, d, 4'hF);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        logic k1, k2, k3, k4;
        xfer(a, 1'b0, 32'h0, 4'hF, d, k1, k2, k3, k4);
    endtask

    // Cycles (edges after the enabling write edge) until int_o is seen high.
    task automatic wait_int(output int k);
        k = 1;
        while (int_o !== 1'b1 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    // Reference: apply t ticks to a COUNT/COMPARE pair.
    function automatic void model(input logic [31:0] c0, input logic [31:0] cmp,
                                  input bit au, input int t,
                                  output logic [31:0] c, output bit pend);
        c    = c0;
        pend = 1'b0;
        for (int i = 0; i < t; i++) begin
            if (c == cmp) begin
                pend = 1'b1;
                c    = au ? 32'h0 : c + 32'd1;
            end else begin
                c = c + 32'd1;
            end
        end
    endfunction

    initial begin
        logic [31:0] rv;
        logic        a1, e1, a2, e2;
        int          k;
        logic [31:0] exp_b [4];
        logic [31:0] regs_exp [4];

        bus.wb_adr_i = 32'h0;
        bus.wb_dat_i = 32'h0;
        bus.wb_sel_i = 4'h0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cti_i = 3'b000;
        bus.wb_bte_i = 2'b00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {28'h0, bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o, int_o}, 32'h0);
        check("reset dat_o", bus.wb_dat_o, 32'h0);
        rst = 1'b0;
        idle(1);

        // Reset values and single-cycle ack timing.
        regs_exp[0] = 32'h0;
        regs_exp[1] = 32'h0;
        regs_exp[2] = 32'hFFFF_FFFF;
        regs_exp[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            xfer(32'(4 * i), 1'b0, 32'h0, 4'hF, rv, a1, e1, a2, e2);
            check($sformatf("reset read 0x%02h", 4 * i), rv, regs_exp[i]);
            check($sformatf("ack pulse 0x%02h", 4 * i), {28'h0, a1, a2, e1, e2}, 32'h8);
        end

        // PRESCALE 0, compare 5: match on the 6th tick after enable.
        wr(c_a_compare, 32'd5);
        wr(c_a_ctrl, 32'h0000_0003);
        wait_int(k);
        check("int rise cycles p0", 32'(k), 32'd6);

        // PRESCALE 3 with AUTO, compare 2: match every 12 cycles.
        wr(c_a_ctrl, 32'h0);
        wr(c_a_count, 32'h0);
        wr(c_a_status, 32'h1);
        wr(c_a_compare, 32'd2);
        wr(c_a_ctrl, 32'h0000_0307);
        wait_int(k);
        check("int rise cycles p3 auto", 32'(k), 32'd12);
        wr(c_a_status, 32'h1);         // clears at E+13
        idle(9);
        wr(c_a_status, 32'h1);         // clear on the E+24 match edge
        check("set beats clear int", {31'h0, int_o}, 32'h1);
        rd(c_a_status, rv);
        check("set beats clear pend", rv, 32'h1);
        idle(9);
        wr(c_a_status, 32'h1);         // clear one edge after the E+36 match
        check("late clear int", {31'h0, int_o}, 32'h0);
        rd(c_a_status, rv);
        check("late clear pend", rv, 32'h0);

        // IE masks int_o without touching PEND.
        wr(c_a_ctrl, 32'h0);
        wr(c_a_count, 32'd5);
        wr(c_a_compare, 32'd5);
        wr(c_a_ctrl, 32'h0000_0003);
        wr(c_a_ctrl, 32'h0);
        check("ie masked int", {31'h0, int_o}, 32'h0);
        rd(c_a_status, rv);
        check("ie masked pend", rv, 32'h1);
        wr(c_a_ctrl, 32'h0000_0002);
        check("ie unmask int", {31'h0, int_o}, 32'h1);
        wr(c_a_status, 32'h1);
        check("status clear int", {31'h0, int_o}, 32'h0);

        // Wrap-around: one tick takes all-ones to zero with no match.
        wr(c_a_ctrl, 32'h0);
        wr(c_a_status, 32'h1);
        wr(c_a_count, 32'hFFFF_FFFF);
        wr(c_a_compare, 32'd5);
        wr(c_a_ctrl, 32'h0000_0103);
        wr(c_a_ctrl, 32'h0000_0102);
        rd(c_a_count, rv);
        check("wrap count", rv, 32'h0);
        rd(c_a_status, rv);
        check("wrap pend", rv, 32'h0);

        // COUNT write on a tick edge wins; two more ticks follow.
        wr(c_a_ctrl, 32'h0);
        wr(c_a_count, 32'd100);
        wr(c_a_ctrl, 32'h0000_0001);
        wr(c_a_count, 32'h0000_1234);
        wr(c_a_ctrl, 32'h0);
        rd(c_a_count, rv);
        check("count write wins", rv, 32'h0000_1236);

        // Byte lanes and reserved CTRL bits.
        wr_sel(c_a_compare, 32'hAABB_CCDD, 4'b0101);
        rd(c_a_compare, rv);
        check("byte lane compare", rv, 32'h00BB_00DD);
        wr(c_a_ctrl, 32'hFFFF_A506);
        rd(c_a_ctrl, rv);
        check("ctrl reserved bits", rv, 32'h0000_A506);
        rd(32'h0000_000B, rv);
        check("adr[1:0] ignored", rv, 32'h00BB_00DD);

        // Unmapped offsets: err pulse, no ack, no register change.
        xfer(32'h10, 1'b1, 32'h1234_5678, 4'hF, rv, a1, e1, a2, e2);
        check("err write handshake", {28'h0, a1, e1, a2, e2}, 32'h4);
        xfer(32'hFC, 1'b0, 32'h0, 4'hF, rv, a1, e1, a2, e2);
        check("err read handshake", {28'h0, a1, e1, a2, e2}, 32'h4);
        check("err read data", rv, 32'h0);
        rd(c_a_count, rv);
        check("err count unchanged", rv, 32'h0000_1236);
        rd(c_a_ctrl, rv);
        check("err ctrl unchanged", rv, 32'h0000_A506);

        // 4-beat incrementing burst from 0x00.
        exp_b[0] = 32'h0000_A506;
        exp_b[1] = 32'h0000_1236;
        exp_b[2] = 32'h00BB_00DD;
        exp_b[3] = 32'h0;
        bus.wb_adr_i = 32'h0;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'hF;
        bus.wb_cti_i = 3'b010;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(posedge clk);
            #1;
            check($sformatf("burst ack %0d", b), {31'h0, bus.wb_ack_o}, 32'h1);
            check($sformatf("burst data %0d", b), bus.wb_dat_o, exp_b[b]);
            bus.wb_adr_i = bus.wb_adr_i + 32'd4;
            bus.wb_cti_i = (b == 2) ? 3'b111 : 3'b010;
            if (b == 3) begin
                bus.wb_cyc_i = 1'b0;
                bus.wb_stb_i = 1'b0;
            end
            @(posedge clk);
            #1;
            check($sformatf("burst gap %0d", b), {31'h0, bus.wb_ack_o}, 32'h0);
        end

        // Reset in the middle of a burst drops the transfer.
        bus.wb_adr_i = 32'h0;
        bus.wb_cti_i = 3'b010;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        @(posedge clk);
        #1;
        check("midburst first ack", {31'h0, bus.wb_ack_o}, 32'h1);
        bus.wb_adr_i = 32'h4;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midburst rst ack/err", {30'h0, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
        @(posedge clk);
        #1;
        check("midburst rst hold", {30'h0, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
        check("midburst rst dat", bus.wb_dat_o, 32'h0);
        rst = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        idle(1);
        rd(c_a_ctrl, rv);
        check("post reset ctrl", rv, 32'h0);
        rd(c_a_compare, rv);
        check("post reset compare", rv, 32'hFFFF_FFFF);

        // Randomized runs against the reference model.
        for (int it = 0; it < 16; it++) begin
            int          p;
            int          n;
            int          t;
            bit          au;
            bit          ie;
            bit          pexp;
            logic [31:0] c0;
            logic [31:0] cmp;
            logic [31:0] cexp;
            logic [31:0] ctrl;
            p   = int'($urandom_range(0, 5));
            n   = int'($urandom_range(0, 40));
            au  = 1'($urandom_range(0, 1));
            ie  = 1'($urandom_range(0, 1));
            cmp = $urandom_range(0, 12);
            if ($urandom_range(0, 3) == 0) begin
                c0 = 32'hFFFF_FFFF - $urandom_range(0, 6);
            end else begin
                c0 = $urandom_range(0, 12);
            end
            ctrl = {16'h0, 8'(p), 5'h0, au, ie, 1'b1};
            wr(c_a_ctrl, 32'h0);
            wr(c_a_status, 32'h1);
            wr(c_a_count, c0);
            wr(c_a_compare, cmp);
            wr(c_a_ctrl, ctrl);            // enable edge E
            idle(n);
            wr(c_a_ctrl, ctrl & ~32'h1);   // disable edge E+2+n still ticks
            t = (n + 2) / (p + 1);
            model(c0, cmp, au, t, cexp, pexp);
            rd(c_a_count, rv);
            check($sformatf("rnd %0d count", it), rv, cexp);
            rd(c_a_status, rv);
            check($sformatf("rnd %0d pend", it), rv, {31'h0, pexp});
            check($sformatf("rnd %0d int", it), {31'h0, int_o}, {31'h0, pexp & ie});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_tick_timer.md
Name: wb_tick_timer

Overview:
- Wishbone B3 slave timer/interrupt source; sits on the system Wishbone interconnect beside main RAM and UART.
- Drives one OR1200 programmable interrupt line (pic_ints_i[3]), giving the CPU a periodic tick.
- Software programs prescaler, compare value and mode; block counts and raises a level interrupt on compare match.

Parameters:
- CNT_W, 32, counter and compare width (1..32); register reads are zero-extended to 32 bits.
- RST_PRESCALE, 8'd0, reset value of CTRL.PRESCALE.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous active-high reset.
- wb_adr_i  in  32  byte address; bits [7:2] decoded.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte lane enables, honoured on writes.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type; classic, incrementing and end-of-burst all accepted.
- wb_bte_i  in  2  burst type; ignored.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  error acknowledge.
- wb_rty_o  out  1  tied 0.
- int_o  out  1  interrupt request, level.

Behaviour:
- Register map (offset = wb_adr_i[7:0]):
  - 0x00 CTRL: [0] EN, [1] IE, [2] AUTO (reload to 0 on match), [15:8] PRESCALE; all other bits read 0.
  - 0x04 COUNT: read/write.
  - 0x08 COMPARE: read/write.
  - 0x0C STATUS: [0] PEND; writing 1 clears, writing 0 has no effect.
- Bus handshake:
  - req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o.
  - Offsets 0x00-0x0C: wb_ack_o registered and high for exactly one cycle, the cycle after req. Each burst beat costs 2 cycles.
  - Offsets 0x10-0xFF: wb_err_o asserts with the same timing instead of ack; no register changes.
  - wb_adr_i[1:0] ignored.
  - Write takes effect on the req edge; only lanes with wb_sel_i=1 update.
  - wb_dat_o is registered on the req edge, valid while ack is high, and 0 otherwise.
- Prescaler (8-bit pre_cnt):
  - When EN=1: if pre_cnt==PRESCALE then tick=1 and pre_cnt<=0, else pre_cnt<=pre_cnt+1.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
  - When EN=0: pre_cnt<=0, no ticks.
- Counting on tick:
  - If COUNT==COMPARE: PEND<=1, and COUNT<=AUTO?0:COUNT+1.
  - Otherwise COUNT<=COUNT+1.
  - Wrap-around: COUNT wraps modulo 2^CNT_W (all ones to 0) silently.
- Interrupt: int_o = PEND & IE, both registered, so int_o is glitch-free. Clearing IE masks int_o without clearing PEND.
- Simultaneous events:
  - Bus write to COUNT on a tick cycle: write wins; no compare evaluated that cycle.
  - STATUS clear on the same cycle as a match: set wins, PEND stays 1.
  - Write to CTRL with EN going 0->1: pre_cnt restarts from 0.
- Reset (any cycle, including mid-transfer): CTRL={RST_PRESCALE,5'b0,AUTO=0,IE=0,EN=0}; COUNT=0; COMPARE=all ones; PEND=0; pre_cnt=0. Outputs wb_ack_o, wb_err_o, wb_dat_o and int_o all 0. A transfer in flight is dropped; the master must reissue it.

Test Plan:
- Reset then read 0x00, 0x04, 0x08, 0x0C -> 0x0000_0000, 0x0, 0xFFFF_FFFF, 0x0. Each ack is a 1-cycle pulse, 1 cycle after stb.
- Write COMPARE=5, CTRL=0x0000_0003 (PRESCALE 0, EN, IE) -> PEND and int_o rise on the tick where COUNT==5; COUNT reads 6 next.
- Set CTRL=0x0000_0307 (PRESCALE 3, AUTO), COMPARE=2 -> one tick per 4 cycles; COUNT sequence 0,1,2,0,1,2; int_o first high 12 cycles after enable.
- Clear PEND on the exact match cycle -> PEND remains 1. Repeat with the clear one cycle later -> int_o drops the cycle after ack.
- COUNT=0xFFFF_FFFF with EN -> next tick gives COUNT=0, no PEND (COMPARE=5). A COUNT write colliding with a tick stores the written value.
- 4-beat incrementing burst read at 0x00 with cti=010,010,010,111 -> 4 acks with correct data. Access to 0x10 -> wb_err_o pulse, no ack, registers unchanged. Reset asserted mid-burst -> ack and err low the next cycle.
